// File: rtl/vga_window_scaler.sv
// VGA timing generator with a windowed frame-buffer reader, optional 2x pixel/line
// replication and a border colour; all VGA outputs are aligned three clocks after the counters.
module vga_window_scaler #(
    parameter int H_RES     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_RES     = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int WIN_X     = 160,
    parameter int WIN_Y     = 120,
    parameter int WIN_W     = 320,
    parameter int WIN_H     = 240,
    parameter int SCALE     = 1,
    parameter int ADDR_W    = 17,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic [15:0]       frame_pixel,
    input  logic [11:0]       border_color,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [3:0]        vga_red,
    output logic [3:0]        vga_green,
    output logic [3:0]        vga_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [9:0]        hcnt,
    output logic [9:0]        vcnt,
    output logic              frame_start
);

    localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);
    localparam int X_END_I = (WIN_X + WIN_W * SCALE < H_RES) ? WIN_X + WIN_W * SCALE : H_RES;
    localparam int Y_END_I = (WIN_Y + WIN_H * SCALE < V_RES) ? WIN_Y + WIN_H * SCALE : V_RES;

    localparam logic [HW-1:0] H_ZERO = HW'(0);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_RES);
    localparam logic [HW-1:0] X_BEG  = HW'(WIN_X);
    localparam logic [HW-1:0] X_END  = HW'(X_END_I);
    localparam logic [HW-1:0] HS_BEG = HW'(H_RES + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_RES + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ZERO = VW'(0);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_RES);
    localparam logic [VW-1:0] Y_BEG  = VW'(WIN_Y);
    localparam logic [VW-1:0] Y_END  = VW'(Y_END_I);
    localparam logic [VW-1:0] VS_BEG = VW'(V_RES + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_RES + V_FP + V_SYNC);
    localparam logic          REP_LAST = 1'(SCALE - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIN_W);

    logic [HW-1:0]     h_r, h_nxt_s;
    logic [VW-1:0]     v_r, v_nxt_s;
    logic              run_r, frame_start_r;
    logic [9:0]        sx_r, sy_r;
    logic              col_rep_r, line_rep_r;
    logic [ADDR_W-1:0] line_base_r;
    logic              in_act_s, win_row_s, win_s, hs_on_s, vs_on_s, line_end_s, frame_end_s;
    logic              win1_r, act1_r, hs1_r, vs1_r;
    logic              win2_r, act2_r, hs2_r, vs2_r;

    assign frame_start = frame_start_r;

    // Next raster position
    always_comb begin
        h_nxt_s = h_r;
        v_nxt_s = v_r;
        if (h_r == H_LAST) begin
            h_nxt_s = H_ZERO;
            v_nxt_s = (v_r == V_LAST) ? V_ZERO : v_r + V_ONE;
        end else begin
            h_nxt_s = h_r + H_ONE;
            v_nxt_s = v_r;
        end
    end

    // Region decode for the current raster position; run_r masks the post-reset priming cycle
    always_comb begin
        in_act_s    = run_r && (h_r < H_ACT) && (v_r < V_ACT);
        win_row_s   = (v_r >= Y_BEG) && (v_r < Y_END);
        win_s       = run_r && win_row_s && (h_r >= X_BEG) && (h_r < X_END);
        hs_on_s     = run_r && (h_r >= HS_BEG) && (h_r < HS_END);
        vs_on_s     = run_r && (v_r >= VS_BEG) && (v_r < VS_END);
        line_end_s  = run_r && win_row_s && (h_r == H_LAST);
        frame_end_s = run_r && (h_r == H_LAST) && (v_r == V_LAST);
    end

    // Raster counters; the first clock after reset parks at (0,0) to raise frame_start
    always_ff @(posedge clk25) begin
        if (rst) begin
            h_r           <= H_ZERO;
            v_r           <= V_ZERO;
            run_r         <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (!run_r) begin
            run_r         <= 1'b1;
            frame_start_r <= 1'b1;
        end else begin
            h_r           <= h_nxt_s;
            v_r           <= v_nxt_s;
            frame_start_r <= (h_nxt_s == H_ZERO) && (v_nxt_s == V_ZERO);
        end
    end

    // Source coordinates and line base, stepped by the replication counters
    always_ff @(posedge clk25) begin
        if (rst) begin
            sx_r        <= 10'd0;
            col_rep_r   <= 1'b0;
            sy_r        <= 10'd0;
            line_rep_r  <= 1'b0;
            line_base_r <= '0;
        end else begin
            if (win_s) begin
                if (col_rep_r == REP_LAST) begin
                    col_rep_r <= 1'b0;
                    sx_r      <= sx_r + 10'd1;
                end else begin
                    col_rep_r <= col_rep_r + 1'b1;
                end
            end else begin
                col_rep_r <= 1'b0;
                sx_r      <= 10'd0;
            end
            if (frame_end_s) begin
                line_rep_r  <= 1'b0;
                sy_r        <= 10'd0;
                line_base_r <= '0;
            end else if (line_end_s) begin
                if (line_rep_r == REP_LAST) begin
                    line_rep_r  <= 1'b0;
                    sy_r        <= sy_r + 10'd1;
                    line_base_r <= line_base_r + LINE_STEP;
                end else begin
                    line_rep_r <= line_rep_r + 1'b1;
                end
            end
        end
    end

    // Stage 1: buffer address and source coordinates, with the matching flags
    always_ff @(posedge clk25) begin
        if (rst) begin
            frame_addr <= '0;
            hcnt       <= 10'd0;
            vcnt       <= 10'd0;
            win1_r     <= 1'b0;
            act1_r     <= 1'b0;
            hs1_r      <= ~HSYNC_POL;
            vs1_r      <= ~VSYNC_POL;
        end else begin
            frame_addr <= win_s ? line_base_r + ADDR_W'(sx_r) : '0;
            hcnt       <= win_s ? sx_r : 10'd0;
            vcnt       <= win_s ? sy_r : 10'd0;
            win1_r     <= win_s;
            act1_r     <= in_act_s;
            hs1_r      <= hs_on_s ? HSYNC_POL : ~HSYNC_POL;
            vs1_r      <= vs_on_s ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    // Stage 2: flags wait while the buffer returns the pixel
    always_ff @(posedge clk25) begin
        if (rst) begin
            win2_r <= 1'b0;
            act2_r <= 1'b0;
            hs2_r  <= ~HSYNC_POL;
            vs2_r  <= ~VSYNC_POL;
        end else begin
            win2_r <= win1_r;
            act2_r <= act1_r;
            hs2_r  <= hs1_r;
            vs2_r  <= vs1_r;
        end
    end

    // Stage 3: colour select and sync outputs
    always_ff @(posedge clk25) begin
        if (rst) begin
            {vga_red, vga_green, vga_blue} <= 12'h000;
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
        end else begin
            if (win2_r) begin
                {vga_red, vga_green, vga_blue} <= {frame_pixel[15:12], frame_pixel[10:7], frame_pixel[4:1]};
            end else if (act2_r) begin
                {vga_red, vga_green, vga_blue} <= border_color;
            end else begin
                {vga_red, vga_green, vga_blue} <= 12'h000;
            end
            vga_hsync <= hs2_r;
            vga_vsync <= vs2_r;
        end
    end

endmodule

// File: tb/tb_vga_window_scaler.sv
// Bench for vga_window_scaler: two reduced-size instances (1x window, and 2x window with
// high-true syncs) checked every cycle against a raster model plus hand-computed points.
module tb_vga_window_scaler;

    localparam int HR = 64, HFP = 4, HSY = 8, HBP = 4, HT = HR + HFP + HSY + HBP;
    localparam int VR = 48, VFP = 2, VSY = 2, VBP = 3, VT = VR + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       fs;
        logic [9:0] addr;
        logic [9:0] hc;
        logic [9:0] vc;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] border = 12'h00F;
    logic [15:0] fp_a = 16'h0000, fp_b = 16'h0000;
    logic [9:0]  addr_a, addr_b, hc_a, hc_b, vc_a, vc_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
    int n = -1;
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_window_scaler #(
        .H_RES(HR), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_RES(VR), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .WIN_X(16), .WIN_Y(12), .WIN_W(32), .WIN_H(24), .SCALE(1), .ADDR_W(10),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_a (
        .clk25(clk), .rst(rst), .frame_pixel(fp_a), .border_color(border),
        .frame_addr(addr_a), .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .hcnt(hc_a), .vcnt(vc_a), .frame_start(fs_a)
    );

    vga_window_scaler #(
        .H_RES(HR), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_RES(VR), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .WIN_X(16), .WIN_Y(12), .WIN_W(16), .WIN_H(12), .SCALE(2), .ADDR_W(10),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_b (
        .clk25(clk), .rst(rst), .frame_pixel(fp_b), .border_color(border),
        .frame_addr(addr_b), .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .hcnt(hc_b), .vcnt(vc_b), .frame_start(fs_b)
    );

    function automatic logic [15:0] pixfn(input int a);
        return 16'(a * 37) ^ 16'h5A3C;
    endfunction

    // Frame position: -1 while reset is in force, 0 on the first frame_start afterwards
    always @(posedge clk) begin
        if (rst) n <= -1;
        else     n <= n + 1;
    end

    // One-cycle-latency frame buffers; all-ones during the first frame after reset
    always @(posedge clk) begin
        fp_a <= (n < FRAME) ? 16'hFFFF : pixfn(int'(addr_a));
        fp_b <= (n < FRAME) ? 16'hFFFF : pixfn(int'(addr_b));
    end

    // Expected outputs at frame position nn for a window (wx,wy,ww,wh) scaled by sc
    function automatic obs_t model(input int nn, input int wx, input int wy, input int ww,
                                   input int wh, input int sc, input bit pol);
        obs_t e;
        int p, h, v, a;
        logic [15:0] pix;
        e = '0;
        e.hs = ~pol;
        e.vs = ~pol;
        e.fs = (nn >= 0) && (nn % FRAME == 0);
        if (nn - 1 >= 0) begin
            p = (nn - 1) % FRAME; h = p % HT; v = p / HT;
            if (h >= wx && h < wx + ww * sc && h < HR && v >= wy && v < wy + wh * sc && v < VR) begin
                e.hc   = 10'((h - wx) / sc);
                e.vc   = 10'((v - wy) / sc);
                e.addr = 10'(((v - wy) / sc) * ww + (h - wx) / sc);
            end
        end
        if (nn - 3 >= 0) begin
            p = (nn - 3) % FRAME; h = p % HT; v = p / HT;
            e.hs = (h >= HR + HFP && h < HR + HFP + HSY) ? pol : ~pol;
            e.vs = (v >= VR + VFP && v < VR + VFP + VSY) ? pol : ~pol;
            if (h >= wx && h < wx + ww * sc && h < HR && v >= wy && v < wy + wh * sc && v < VR) begin
                a = ((v - wy) / sc) * ww + (h - wx) / sc;
                pix = (nn - 2 < FRAME) ? 16'hFFFF : pixfn(a);
                e.rgb = {pix[15:12], pix[10:7], pix[4:1]};
            end else if (h < HR && v < VR) begin
                e.rgb = border;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at n=%0d: actual %0h required %0h", name, n, act, exp);
        end
    endtask

    task automatic cmp_inst(input string nm, input obs_t e, input obs_t a);
        chk({nm, "_frame_start"}, 32'(a.fs), 32'(e.fs));
        chk({nm, "_frame_addr"}, 32'(a.addr), 32'(e.addr));
        chk({nm, "_hcnt"}, 32'(a.hc), 32'(e.hc));
        chk({nm, "_vcnt"}, 32'(a.vc), 32'(e.vc));
        chk({nm, "_rgb"}, 32'(a.rgb), 32'(e.rgb));
        chk({nm, "_hsync"}, 32'(a.hs), 32'(e.hs));
        chk({nm, "_vsync"}, 32'(a.vs), 32'(e.vs));
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("a", model(n, 16, 12, 32, 24, 1, 1'b0),
                     {fs_a, addr_a, hc_a, vc_a, r_a, g_a, b_a, hs_a, vs_a});
            cmp_inst("b", model(n, 16, 12, 16, 12, 2, 1'b1),
                     {fs_b, addr_b, hc_b, vc_b, r_b, g_b, b_b, hs_b, vs_b});
        end
    end

    task automatic wait_n(input int target);
        int g;
        g = 0;
        while (n != target && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_position", 32'(n), 32'(target));
    endtask

    task automatic chk_reset_state();
        chk("rst_rgb_a", {20'h0, r_a, g_a, b_a}, 32'h0);
        chk("rst_hsync_a", 32'(hs_a), 32'h1);
        chk("rst_vsync_a", 32'(vs_a), 32'h1);
        chk("rst_addr_a", 32'(addr_a), 32'h0);
        chk("rst_fs_a", 32'(fs_a), 32'h0);
        chk("rst_hsync_b", 32'(hs_b), 32'h0);
        chk("rst_vsync_b", 32'(vs_b), 32'h0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk_reset_state();
        rst = 1'b0;
        @(negedge clk);
        chk("fs_after_release", 32'(fs_a), 32'h1);
        wait_n(3);    chk("rgb_a_origin_border", {20'h0, r_a, g_a, b_a}, 32'h00F);
        wait_n(70);   chk("hsync_a_before", 32'(hs_a), 32'h1);
        wait_n(71);   chk("hsync_a_first", 32'(hs_a), 32'h0);
                      chk("hsync_b_first", 32'(hs_b), 32'h1);
        wait_n(73);   chk("rgb_a_blank", {20'h0, r_a, g_a, b_a}, 32'h000);
        wait_n(78);   chk("hsync_a_last", 32'(hs_a), 32'h0);
        wait_n(79);   chk("hsync_a_after", 32'(hs_a), 32'h1);
        wait_n(977);  chk("addr_a_first", 32'(addr_a), 32'd0);
                      chk("addr_b_first", 32'(addr_b), 32'd0);
        wait_n(978);  chk("addr_b_held", 32'(addr_b), 32'd0);
        wait_n(979);  chk("addr_b_second", 32'(addr_b), 32'd1);
                      chk("rgb_a_window_corner", {20'h0, r_a, g_a, b_a}, 32'hFFF);
        wait_n(1008); chk("addr_a_line_end", 32'(addr_a), 32'd31);
                      chk("hcnt_b_line_end", 32'(hc_b), 32'd15);
        wait_n(1057); chk("addr_a_line2", 32'(addr_a), 32'd32);
                      chk("addr_b_line_repeat", 32'(addr_b), 32'd0);
        wait_n(1137); chk("addr_b_src_line1", 32'(addr_b), 32'd16);
                      chk("vcnt_b_src_line1", 32'(vc_b), 32'd1);
        wait_n(1138); chk("addr_b_src_line1_held", 32'(addr_b), 32'd16);
        wait_n(2848); chk("addr_a_last", 32'(addr_a), 32'd767);
        wait_n(2897); chk("addr_a_below_window", 32'(addr_a), 32'd0);
        wait_n(4002); chk("vsync_a_before", 32'(vs_a), 32'h1);
        wait_n(4003); chk("vsync_a_first", 32'(vs_a), 32'h0);
                      chk("vsync_b_first", 32'(vs_b), 32'h1);
        wait_n(4162); chk("vsync_a_last", 32'(vs_a), 32'h0);
        wait_n(4163); chk("vsync_a_after", 32'(vs_a), 32'h1);
        wait_n(2 * FRAME + 20 * HT + 30);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("fs_after_midframe_reset", 32'(fs_a), 32'h1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (fs_a !== 1'b1 && cnt < 5000);
        chk("frame_period", 32'(cnt), 32'(FRAME));
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
